// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    // Identifies which requester owns the write port.
    typedef enum logic {
        ARB_SRC_ALU = 1'b0,
        ARB_SRC_LSU = 1'b1
    } arb_src_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request channel: one instance per requester (ALU, LSU).
// The requester drives valid/rd/data and the arbiter answers with ready.
interface rf_wb_arbiter_if
    import rf_wb_arbiter_pkg::*;
#(
    parameter int WORD_W = WORD_WIDTH,
    parameter int ADDR_W = REG_ADDR_WIDTH
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] rd;
    logic [WORD_W-1:0] data;

    modport master (output valid, rd, data, input ready);
    modport slave  (input valid, rd, data, output ready);
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard. Issue sets an entry, a granted writeback
// clears it, and two source registers can be queried for RAW hazards.
// Register 0 is never tracked as busy.
module rf_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int NREGS  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_iss_valid,
    output logic              o_iss_ready,
    input  logic [ADDR_W-1:0] i_iss_rd,
    input  logic              i_clr_en,
    input  logic [ADDR_W-1:0] i_clr_idx,
    input  logic [ADDR_W-1:0] i_q_rs1,
    input  logic [ADDR_W-1:0] i_q_rs2,
    output logic              o_q_hazard
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_set_mask;
    logic [NREGS-1:0] w_clr_mask;

    // Issue acceptance, set/clear masks and the hazard query.
    always_comb begin
        w_set_mask  = '0;
        w_clr_mask  = '0;
        o_iss_ready = rst_n && ((i_iss_rd == '0) || !r_busy[i_iss_rd]);
        if (i_iss_valid && o_iss_ready && (i_iss_rd != '0))
            w_set_mask[i_iss_rd] = 1'b1;
        if (i_clr_en)
            w_clr_mask[i_clr_idx] = 1'b1;
        o_q_hazard = ((i_q_rs1 != '0) && r_busy[i_q_rs1]) ||
                     ((i_q_rs2 != '0) && r_busy[i_q_rs2]);
    end

    // Busy vector: a set and a clear of different entries both land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_busy <= '0;
        else
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single register-file write port between the ALU and LSU
// writeback paths and owns the busy scoreboard used by decode to stall.
// Ties go round-robin by default; defining RF_ARB_LSU_PRIO_EN makes the
// LSU win every tie instead.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int WORD_W = WORD_WIDTH,
    parameter int ADDR_W = REG_ADDR_WIDTH,
    parameter int NREGS  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    rf_wb_arbiter_if.slave    alu,
    rf_wb_arbiter_if.slave    lsu,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [ADDR_W-1:0] q_rs1,
    input  logic [ADDR_W-1:0] q_rs2,
    output logic              q_hazard,
    output logic              rf_w_en,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [WORD_W-1:0] rf_wd
);

    logic              w_alu_req;
    logic              w_lsu_req;
    logic              w_alu_grant;
    logic              w_lsu_grant;
    logic              w_grant;
    logic [ADDR_W-1:0] w_grant_rd;
    logic [WORD_W-1:0] w_grant_data;

    logic              r_rf_w_en;
    logic [ADDR_W-1:0] r_rf_wa;
    logic [WORD_W-1:0] r_rf_wd;

`ifndef RF_ARB_LSU_PRIO_EN
    arb_src_e          r_last_grant;
`endif

    // Pick the winner among requests that actually need the port (rd != 0).
    always_comb begin
        w_alu_req   = rst_n && alu.valid && (alu.rd != '0);
        w_lsu_req   = rst_n && lsu.valid && (lsu.rd != '0);
        w_alu_grant = 1'b0;
        w_lsu_grant = 1'b0;
        if (w_alu_req && w_lsu_req) begin
`ifdef RF_ARB_LSU_PRIO_EN
            w_lsu_grant = 1'b1;
`else
            if (r_last_grant == ARB_SRC_LSU)
                w_alu_grant = 1'b1;
            else
                w_lsu_grant = 1'b1;
`endif
        end else begin
            w_alu_grant = w_alu_req;
            w_lsu_grant = w_lsu_req;
        end
        w_grant      = w_alu_grant || w_lsu_grant;
        w_grant_rd   = w_lsu_grant ? lsu.rd   : alu.rd;
        w_grant_data = w_lsu_grant ? lsu.data : alu.data;
    end

    // rd==0 requests are acknowledged at once without using the port.
    assign alu.ready = rst_n && alu.valid && ((alu.rd == '0) || w_alu_grant);
    assign lsu.ready = rst_n && lsu.valid && ((lsu.rd == '0) || w_lsu_grant);

    // Registered write port toward reg_file; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_w_en <= 1'b0;
            r_rf_wa   <= '0;
            r_rf_wd   <= '0;
        end else begin
            r_rf_w_en <= w_grant;
            if (w_grant) begin
                r_rf_wa <= w_grant_rd;
                r_rf_wd <= w_grant_data;
            end
        end
    end

`ifndef RF_ARB_LSU_PRIO_EN
    // Remember the last real grant so the other requester wins the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last_grant <= ARB_SRC_LSU;
        else if (w_alu_grant)
            r_last_grant <= ARB_SRC_ALU;
        else if (w_lsu_grant)
            r_last_grant <= ARB_SRC_LSU;
    end
`endif

    assign rf_w_en = r_rf_w_en;
    assign rf_wa   = r_rf_wa;
    assign rf_wd   = r_rf_wd;

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_iss_valid (iss_valid),
        .o_iss_ready (iss_ready),
        .i_iss_rd    (iss_rd),
        .i_clr_en    (w_grant),
        .i_clr_idx   (w_grant_rd),
        .i_q_rs1     (q_rs1),
        .i_q_rs2     (q_rs2),
        .o_q_hazard  (q_hazard)
    );

endmodule
